square_noise: RTL and testbench
===============================

SQUARE_NOISE -- requirements
Module: square_noise

Interface
REQ-001 SHALL have parameter FRAME_DIV, default 29830: clk cycles per frame_tick pulse.
REQ-002 SHALL have parameter SEQ_W, default 3: square duty-sequencer index width (8 steps).
REQ-003 clk  input  1  single system clock (CPU rate); all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 sq_r0  input  8  [7:6] duty select, [3:0] square volume (constant).
REQ-006 sq_r2  input  8  square period bits [7:0].
REQ-007 sq_r3  input  8  [2:0] square period bits [10:8]; [7:3] ignored.
REQ-008 noise_rc  input  8  [3:0] noise volume; other bits ignored.
REQ-009 noise_re  input  8  [3:0] period index, [7] mode; [6:4] ignored.
REQ-010 noise_rf  input  8  ignored (length load belongs to the length counter).
REQ-011 sq_out  output  4  registered square channel sample.
REQ-012 noise_out  output  4  registered noise channel sample.
REQ-013 frame_tick  output  1  one-clk pulse every FRAME_DIV clks.

Function
REQ-014 Register inputs are static levels sampled every clk; no write strobes; changes take effect at the next timer reload.
REQ-015 Divider: counter 0..FRAME_DIV-1; frame_tick=1 for the single cycle when count==FRAME_DIV-1, counter then wraps to 0.
REQ-016 APU tick: 1-bit toggle every clk; square timer runs only on cycles where toggle==1 (half clk rate).
REQ-017 Square period P = {sq_r3[2:0], sq_r2} (11 bits); on APU tick, timer==0 -> reload P and step=(step+1) mod 8, else timer-1.
REQ-018 Duty patterns, step 0..7: duty0 01000000; duty1 01100000; duty2 01111000; duty3 10011111.
REQ-019 sq_out <= (pattern[duty][step]==1 and P>=8) ? sq_r0[3:0] : 0; one clk latency; P<8 mutes.
REQ-020 Square full waveform = 16*(P+1) clks.
REQ-021 Noise period table (clks), index 0..15: 4,8,16,32,64,96,128,160,202,254,380,508,762,1016,2034,4068.
REQ-022 Noise timer runs every clk; on 0 reloads table[idx]-1 and shifts LFSR; else decrements; LFSR shifts once per table[idx] clks.
REQ-023 LFSR 15 bits; feedback = bit0 XOR (mode ? bit6 : bit1); shift right, feedback into bit14.
REQ-024 noise_out <= (lfsr[0]==0) ? noise_rc[3:0] : 0; one clk latency.
REQ-025 LFSR SHALL never reach all-zero; no other lock-up protection required.

Reset
REQ-026 rst_n low asynchronously: sq_out=0, noise_out=0, frame_tick=0, divider count=0, APU toggle=0, square timer=0, step=0, noise timer=0, LFSR=15'h0001.
REQ-027 Reset mid-operation aborts all counting; after release, first frame_tick occurs FRAME_DIV clks later.

Configuration
REQ-028 Macro NOISE_CHANNEL_EN defined: noise timer and LFSR built per REQ-021..025.
REQ-029 NOISE_CHANNEL_EN undefined: no noise logic; noise_out tied to 0; all other behaviour unchanged.

Verification
REQ-030 FRAME_DIV=29830, release reset -> frame_tick pulses at clk 29830, 59660; each pulse exactly 1 clk wide.
REQ-031 sq_r0=8'h84, sq_r2=8'h60, sq_r3=0 -> sq_out alternates 4 for 776 clks and 0 for 776 clks (period 1552).
REQ-032 sq_r2=8'h07, sq_r3=0, any duty/volume -> sq_out stays 0; sq_r2=8'h08 -> toggles with period 144 clks.
REQ-033 noise_rc=8'h01, noise_re=8'h05 -> first LFSR shift after 96 clks gives 15'h4000, noise_out=1; further shifts every 96 clks.
REQ-034 noise_re mode=1 (8'h80) from reset -> LFSR sequence follows bit0^bit6 taps (93-step loop vs 32767 for mode 0).
REQ-035 Assert rst_n low mid-waveform -> all outputs 0 immediately, LFSR=1, step=0 without waiting for clk.

Source files
------------

// File: rtl/square_noise_if.sv
// square_noise_if: register levels into the square/noise generator and its samples out.
interface square_noise_if;
    logic [7:0] sq_r0;
    logic [7:0] sq_r2;
    logic [7:0] sq_r3;
    logic [7:0] noise_rc;
    logic [7:0] noise_re;
    logic [7:0] noise_rf;
    logic [3:0] sq_out;
    logic [3:0] noise_out;
    logic       frame_tick;

    modport master (
        output sq_r0, sq_r2, sq_r3, noise_rc, noise_re, noise_rf,
        input  sq_out, noise_out, frame_tick
    );

    modport slave (
        input  sq_r0, sq_r2, sq_r3, noise_rc, noise_re, noise_rf,
        output sq_out, noise_out, frame_tick
    );
endinterface

// File: rtl/square_noise.sv
// square_noise: frame divider, duty-cycle square channel and LFSR noise channel.
// The noise channel is built only when NOISE_CHANNEL_EN is defined; otherwise noise_out is 0.
module square_noise #(
    parameter int FRAME_DIV = 29830,
    parameter int SEQ_W     = 3
) (
    input logic         clk,
    input logic         rst_n,
    square_noise_if.slave bus
);
    localparam int DIV_W = $clog2(FRAME_DIV + 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic             tog_q;
    logic [10:0]      tmr_q, tmr_d;
    logic [SEQ_W-1:0] step_q, step_d;
    logic [3:0]       sq_q, sq_d;
    logic [10:0]      period;
    logic [7:0]       pat;

    assign period = {bus.sq_r3[2:0], bus.sq_r2};

    // Pattern bit n is the level of sequencer step n.
    always_comb begin
        div_d  = (div_q == DIV_W'(FRAME_DIV - 1)) ? '0 : div_q + DIV_W'(1);
        tick_d = (div_d == DIV_W'(FRAME_DIV - 1));
        tmr_d  = !tog_q ? tmr_q : (tmr_q == 11'd0) ? period : tmr_q - 11'd1;
        step_d = (tog_q && tmr_q == 11'd0) ? step_q + SEQ_W'(1) : step_q;
        pat    = (bus.sq_r0[7:6] == 2'd0) ? 8'b0000_0010 :
                 (bus.sq_r0[7:6] == 2'd1) ? 8'b0000_0110 :
                 (bus.sq_r0[7:6] == 2'd2) ? 8'b0001_1110 : 8'b1111_1001;
        sq_d   = (pat[step_q] && period >= 11'd8) ? bus.sq_r0[3:0] : 4'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            tick_q <= 1'b0;
            tog_q  <= 1'b0;
            tmr_q  <= '0;
            step_q <= '0;
            sq_q   <= '0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
            tog_q  <= ~tog_q;
            tmr_q  <= tmr_d;
            step_q <= step_d;
            sq_q   <= sq_d;
        end
    end

    assign bus.sq_out     = sq_q;
    assign bus.frame_tick = tick_q;

`ifdef NOISE_CHANNEL_EN
    // Reload values are table period minus one so the LFSR shifts once per period.
    localparam logic [11:0] NOISE_RELOAD [16] = '{
        12'd3, 12'd7, 12'd15, 12'd31, 12'd63, 12'd95, 12'd127, 12'd159,
        12'd201, 12'd253, 12'd379, 12'd507, 12'd761, 12'd1015, 12'd2033, 12'd4067
    };

    logic [11:0] nt_q, nt_d;
    logic [14:0] lfsr_q, lfsr_d;
    logic [3:0]  noise_q, noise_d;
    logic        fb;
    logic        unused_bits;

    always_comb begin
        fb      = lfsr_q[0] ^ (bus.noise_re[7] ? lfsr_q[6] : lfsr_q[1]);
        nt_d    = (nt_q == 12'd0) ? NOISE_RELOAD[bus.noise_re[3:0]] : nt_q - 12'd1;
        lfsr_d  = (nt_q == 12'd0) ? {fb, lfsr_q[14:1]} : lfsr_q;
        noise_d = lfsr_q[0] ? 4'd0 : bus.noise_rc[3:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nt_q    <= '0;
            lfsr_q  <= 15'h0001;
            noise_q <= '0;
        end else begin
            nt_q    <= nt_d;
            lfsr_q  <= lfsr_d;
            noise_q <= noise_d;
        end
    end

    assign bus.noise_out = noise_q;
    assign unused_bits = ^{bus.sq_r0[5:4], bus.sq_r3[7:3], bus.noise_rc[7:4],
                           bus.noise_re[6:4], bus.noise_rf};
`else
    logic unused_bits;

    assign bus.noise_out = 4'd0;
    assign unused_bits = ^{bus.sq_r0[5:4], bus.sq_r3[7:3], bus.noise_rc,
                           bus.noise_re, bus.noise_rf};
`endif
endmodule

// File: tb/tb_square_noise.sv
// tb_square_noise: scoreboard bench; expected samples come from closed-form timing of each channel.
module tb_square_noise;
    localparam int FD = 29830;

    typedef struct packed {
        logic [3:0] sq;
        logic [3:0] nz;
        logic       tick;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int n_run = 0;
    int n_fail = 0;
    int k, p, t, m_n, n_tick;
    logic [0:7] pat;
    logic [3:0] vol_sq, vol_nz;
    logic mode;
    logic [14:0] m_lfsr;
    exp_t sb[$];

    logic [0:7] duty_tab [4] = '{8'b01000000, 8'b01100000, 8'b01111000, 8'b10011111};
    int noise_tab [16] = '{4, 8, 16, 32, 64, 96, 128, 160, 202, 254, 380, 508, 762, 1016, 2034, 4068};

    square_noise_if bus();

    square_noise #(.FRAME_DIV(FD)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_run++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] lstep(input logic [14:0] s, input logic md);
        return {s[0] ^ (md ? s[6] : s[1]), s[14:1]};
    endfunction

    // Sample after edge kk reflects step/LFSR state after edge kk-1.
    task automatic predict(input int kk, output exp_t e);
        int j, st, tgt;
        j = kk - 1;
        e.tick = (kk % FD) == FD - 1;
        st = (j < 2) ? 0 : ((j - 2) / (2 * (p + 1)) + 1) % 8;
        e.sq = (pat[st] && p >= 8) ? vol_sq : 4'd0;
`ifdef NOISE_CHANNEL_EN
        tgt = (j < 1) ? 0 : (j - 1) / t + 1;
        while (m_n < tgt) begin
            m_lfsr = lstep(m_lfsr, mode);
            m_n++;
        end
        e.nz = m_lfsr[0] ? 4'd0 : vol_nz;
`else
        tgt = t;
        e.nz = 4'd0;
`endif
    endtask

    task automatic run_phase(input logic [7:0] r0, r2, r3, rc, re, input int n, input string name);
        exp_t e, g;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk({name, "_rst_sq"}, bus.sq_out, 0);
        chk({name, "_rst_noise"}, bus.noise_out, 0);
        chk({name, "_rst_tick"}, bus.frame_tick, 0);
        bus.sq_r0 = r0;
        bus.sq_r2 = r2;
        bus.sq_r3 = r3;
        bus.noise_rc = rc;
        bus.noise_re = re;
        bus.noise_rf = 8'($urandom);
        p = {21'd0, r3[2:0], r2};
        pat = duty_tab[r0[7:6]];
        vol_sq = r0[3:0];
        vol_nz = rc[3:0];
        mode = re[7];
        t = noise_tab[re[3:0]];
        m_lfsr = 15'h0001;
        m_n = 0;
        k = 0;
        n_tick = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (n) begin
            k++;
            predict(k, e);
            sb.push_back(e);
            @(posedge clk);
            @(negedge clk);
            g = sb.pop_front();
            n_tick += int'(bus.frame_tick);
            chk({name, "_sq"}, bus.sq_out, g.sq);
            chk({name, "_noise"}, bus.noise_out, g.nz);
            chk({name, "_tick"}, bus.frame_tick, g.tick);
        end
        chk({name, "_tick_count"}, n_tick, (n + 1) / FD);
    endtask

    initial begin
        bus.sq_r0 = '0;
        bus.sq_r2 = '0;
        bus.sq_r3 = '0;
        bus.noise_rc = '0;
        bus.noise_re = '0;
        bus.noise_rf = '0;
        run_phase(8'h84, 8'h60, 8'h00, 8'h01, 8'h05, 59700, "duty2_p96");
        run_phase(8'hCF, 8'h07, 8'h00, 8'h0A, 8'h80, 600, "mute_p7");
        run_phase(8'h49, 8'h08, 8'h00, 8'h03, 8'h0F, 600, "duty1_p8");
        run_phase(8'h0C, 8'h08, 8'hF8, 8'h0F, 8'h8B, 1200, "duty0_p8");
        run_phase(8'hF7, 8'h00, 8'hF9, 8'h56, 8'h7C, 5000, "duty3_p256");
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
